// File: rtl/id3_inst_queue.sv
// rtl/id3_inst_queue.sv - decode2-to-decode3 instruction FIFO with early stall and flush
module id3_inst_queue #(
    parameter int WIDTH  = 32,
    parameter int INST_W = 64,
    parameter int DEPTH  = 8,
    parameter int SKID   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       flush_valid,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_pred_adr,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       stall_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_pred_adr,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

    logic [WIDTH-1:0]  pc_mem   [DEPTH];
    logic [WIDTH-1:0]  pred_mem [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_next;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop at full frees the slot in the same cycle, so the push still lands.
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            stall_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (clk_en) begin
            if (flush_valid) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                stall_out <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count     <= count_next;
                stall_out <= (count_next >= STALL_CNT);
                if (drop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && !flush_valid && push) begin
            pc_mem[wr_ptr]   <= in_pc;
            pred_mem[wr_ptr] <= in_pred_adr;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    assign out_pc       = out_valid ? pc_mem[rd_ptr]   : '0;
    assign out_pred_adr = out_valid ? pred_mem[rd_ptr] : '0;
    assign out_inst     = out_valid ? inst_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_id3_inst_queue.sv
// tb/tb_id3_inst_queue.sv - directed self-checking bench for id3_inst_queue
module tb_id3_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        flush_valid;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_pred_adr;
    logic [63:0] in_inst;
    logic        stall_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pred_adr;
    logic [63:0] out_inst;
    logic [3:0]  count;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id3_inst_queue #(.WIDTH(32), .INST_W(64), .DEPTH(8), .SKID(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .flush_valid  (flush_valid),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_pred_adr  (in_pred_adr),
        .in_inst      (in_inst),
        .stall_out    (stall_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pred_adr (out_pred_adr),
        .out_inst     (out_inst),
        .count        (count),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_inst(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_pred_adr = pc + 32'd4;
        in_inst     = mk_inst(pc);
    endtask

    task automatic push(input logic [31:0] pc);
        present(pc);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clk_en = 1'b1; flush_valid = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_pred_adr = '0; in_inst = '0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_stall", stall_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_pc", out_pc, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // basic order
        push(32'h100); push(32'h104); push(32'h108);
        check("t1_count", count, 3);
        check("t1_head_pc", out_pc, 32'h100);
        check("t1_head_pred", out_pred_adr, 32'h104);
        check("t1_head_inst", out_inst, mk_inst(32'h100));
        check("t1_stall", stall_out, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t1_pop_pc", out_pc, 32'h100 + 32'(4 * k));
            step();
        end
        out_ready = 1'b0;
        check("t1_empty_valid", out_valid, 0);
        check("t1_empty_count", count, 0);

        // stall threshold
        for (int k = 0; k < 5; k++) push(32'h300 + 32'(4 * k));
        check("t2_stall_at5", stall_out, 0);
        push(32'h314);
        check("t2_stall_at6", stall_out, 1);
        push(32'h318);
        check("t2_count7", count, 7);
        check("t2_stall_at7", stall_out, 1);
        out_ready = 1'b1;
        check("t2_pop0_pc", out_pc, 32'h300);
        step();
        check("t2_stall_at6b", stall_out, 1);
        step();
        out_ready = 1'b0;
        check("t2_count5", count, 5);
        check("t2_stall_at5b", stall_out, 0);
        check("t2_head_after2", out_pc, 32'h308);
        flush_valid = 1'b1; step(); flush_valid = 1'b0;
        check("t2_flush_count", count, 0);

        // push+pop at full
        for (int k = 0; k < 8; k++) push(32'h400 + 32'(4 * k));
        check("t3_full_count", count, 8);
        check("t3_full_stall", stall_out, 1);
        present(32'h480); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t3_count_same", count, 8);
        check("t3_head_adv", out_pc, 32'h404);
        check("t3_overflow", overflow, 0);
        for (int k = 1; k < 8; k++) begin
            check("t3_drain_pc", out_pc, 32'h400 + 32'(4 * k));
            step();
        end
        check("t3_tail_pc", out_pc, 32'h480);
        check("t3_tail_inst", out_inst, mk_inst(32'h480));
        step();
        out_ready = 1'b0;
        check("t3_empty", count, 0);

        // overflow
        for (int k = 0; k < 8; k++) push(32'h500 + 32'(4 * k));
        push(32'h5FC);
        check("t4_count", count, 8);
        check("t4_overflow", overflow, 1);
        check("t4_head", out_pc, 32'h500);
        step();
        check("t4_overflow_sticky", overflow, 1);
        flush_valid = 1'b1; step(); flush_valid = 1'b0;
        check("t4_flush_count", count, 0);
        check("t4_flush_overflow", overflow, 0);
        check("t4_flush_stall", stall_out, 0);
        check("t4_flush_valid", out_valid, 0);

        // flush beats push and pop
        for (int k = 0; k < 4; k++) push(32'h600 + 32'(4 * k));
        check("t5_count4", count, 4);
        present(32'h6F0); out_ready = 1'b1; flush_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0; flush_valid = 1'b0;
        check("t5_count", count, 0);
        check("t5_valid", out_valid, 0);
        check("t5_out_pc", out_pc, 0);
        step();
        check("t5_count_later", count, 0);

        // wrap
        for (int k = 0; k < 20; k++) begin
            push(32'h200 + 32'(4 * k));
            out_ready = 1'b1;
            check("t6_wrap_pc", out_pc, 32'h200 + 32'(4 * k));
            check("t6_wrap_inst", out_inst, mk_inst(32'h200 + 32'(4 * k)));
            step();
            out_ready = 1'b0;
        end
        check("t6_wrap_count", count, 0);

        // clock enable hold
        push(32'h700); push(32'h704);
        clk_en = 1'b0; present(32'h7F0); out_ready = 1'b1;
        repeat (3) step();
        check("t7_hold_count", count, 2);
        check("t7_hold_pc", out_pc, 32'h700);
        in_valid = 1'b0; out_ready = 1'b0; clk_en = 1'b1;
        step();
        check("t7_resume_count", count, 2);

        // async reset mid-stream
        rst = 1'b0;
        #1;
        check("t8_rst_valid", out_valid, 0);
        check("t8_rst_count", count, 0);
        rst = 1'b1;
        push(32'h800);
        check("t8_post_count", count, 1);
        check("t8_post_pc", out_pc, 32'h800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
